// File: rtl/gen_scheduler.sv
// Generation scheduler: run/pause/step sequencing, board clear sweep and user cell edits.
// Optional GEN_SCHED_WDOG_EN adds an EVOLVE watchdog with a sticky evo_err output.
module gen_scheduler #(
    parameter int P_PARAM_M = 5,
    parameter int READ_COL  = 5,
    parameter int WIDTH     = 12,
    parameter int DIV_W     = 26,
    parameter int GEN_W     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               clear,
    input  logic [DIV_W-1:0]   period,
    input  logic               evo_done,
    input  logic               edit_req,
    input  logic [2*WIDTH-1:0] edit_addr,
    input  logic               edit_val,
    output logic               edit_gnt,
    output logic               evo_toggle,
    output logic               evo_sel,
    output logic               ram_wden,
    output logic [2*WIDTH-1:0] ram_addr,
    output logic               ram_wdata,
    output logic [GEN_W-1:0]   gen_count,
    output logic               busy
`ifdef GEN_SCHED_WDOG_EN
    ,
    output logic               evo_err
`endif
);

    localparam int CELLS = P_PARAM_M * READ_COL;
    localparam int AW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, EVOLVE, CLEAR} state_t;

    state_t            state, state_n;
    logic              step_q, clr_q;
    logic              pend_step, pend_step_n;
    logic              pend_clr, pend_clr_n;
    logic [DIV_W-1:0]  rate_cnt, rate_n;
    logic [DIV_W-1:0]  period_m1;
    logic [AW-1:0]     clr_addr, clr_addr_n;
    logic              gnt_q, gnt_n;
    logic [AW-1:0]     ea_q, ea_n;
    logic              ev_q, ev_n;
    logic              tog_q, tog_n;
    logic [GEN_W-1:0]  gen_q, gen_n;

`ifdef GEN_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]   wd_cnt, wd_n;
    logic              err_q, err_n;
    assign evo_err = err_q;
`endif

    // A period of 0 behaves like 1: fire on the first IDLE cycle.
    assign period_m1 = (period == '0) ? '0 : period - 1'b1;

    always_comb begin
        state_n     = state;
        pend_step_n = pend_step;
        pend_clr_n  = pend_clr;
        rate_n      = rate_cnt;
        clr_addr_n  = clr_addr;
        gnt_n       = 1'b0;
        ea_n        = ea_q;
        ev_n        = ev_q;
        tog_n       = tog_q;
        gen_n       = gen_q;
`ifdef GEN_SCHED_WDOG_EN
        wd_n        = wd_cnt;
        err_n       = err_q;
`endif
        unique case (state)
            IDLE: begin
                rate_n = run ? rate_cnt + 1'b1 : '0;
                if (run) pend_step_n = 1'b0;
`ifdef GEN_SCHED_WDOG_EN
                wd_n = '0;
`endif
                if (pend_clr) begin
                    state_n     = CLEAR;
                    clr_addr_n  = '0;
                    gen_n       = '0;
                    pend_clr_n  = 1'b0;
                    pend_step_n = 1'b0;
`ifdef GEN_SCHED_WDOG_EN
                    err_n       = 1'b0;
`endif
                end else if (pend_step && !run) begin
                    state_n     = EVOLVE;
                    tog_n       = ~tog_q;
                    pend_step_n = 1'b0;
                end else if (edit_req && !gnt_q) begin
                    gnt_n = 1'b1;
                    ea_n  = edit_addr;
                    ev_n  = edit_val;
                end else if (run && rate_cnt >= period_m1) begin
                    state_n = EVOLVE;
                    tog_n   = ~tog_q;
                    rate_n  = '0;
                end
            end
            EVOLVE: begin
`ifdef GEN_SCHED_WDOG_EN
                wd_n = wd_cnt + 1'b1;
`endif
                if (evo_done) begin
                    state_n = IDLE;
                    gen_n   = gen_q + 1'b1;
                end
`ifdef GEN_SCHED_WDOG_EN
                else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
`endif
            end
            CLEAR: begin
                clr_addr_n = clr_addr + 1'b1;
                if (clr_addr == AW'(CELLS - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // New edges win over same-cycle consumption so no request is lost.
        if (step && !step_q) pend_step_n = 1'b1;
        if (clear && !clr_q) pend_clr_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            step_q    <= 1'b0;
            clr_q     <= 1'b0;
            pend_step <= 1'b0;
            pend_clr  <= 1'b0;
            rate_cnt  <= '0;
            clr_addr  <= '0;
            gnt_q     <= 1'b0;
            ea_q      <= '0;
            ev_q      <= 1'b0;
            tog_q     <= 1'b0;
            gen_q     <= '0;
`ifdef GEN_SCHED_WDOG_EN
            wd_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            step_q    <= step;
            clr_q     <= clear;
            pend_step <= pend_step_n;
            pend_clr  <= pend_clr_n;
            rate_cnt  <= rate_n;
            clr_addr  <= clr_addr_n;
            gnt_q     <= gnt_n;
            ea_q      <= ea_n;
            ev_q      <= ev_n;
            tog_q     <= tog_n;
            gen_q     <= gen_n;
`ifdef GEN_SCHED_WDOG_EN
            wd_cnt    <= wd_n;
            err_q     <= err_n;
`endif
        end
    end

    assign busy       = (state != IDLE);
    assign evo_sel    = (state == EVOLVE);
    assign evo_toggle = tog_q;
    assign gen_count  = gen_q;
    assign edit_gnt   = gnt_q;
    assign ram_wden   = (state == CLEAR) | gnt_q;
    assign ram_addr   = (state == CLEAR) ? clr_addr : (gnt_q ? ea_q : '0);
    assign ram_wdata  = (state != CLEAR) & gnt_q & ev_q;

endmodule
